// File: rtl/shared_mem_responder.sv
// shared_mem_responder: single-port memory serviced by a one-hot arbiter grant,
// with registered completion strobe, read data and saturating service count.
module shared_mem_responder #(
   parameter int Req_Width  = 10,
   parameter int Addr_Width = 4,
   parameter int Data_Width = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [Req_Width-1:0]             gnt,
   input  logic [Req_Width*Addr_Width-1:0]  addr,
   input  logic [Req_Width*Data_Width-1:0]  wdata,
   input  logic [Req_Width-1:0]             we,
   output logic [Req_Width-1:0]             ack,
   output logic                             ack_we,
   output logic [Data_Width-1:0]            rdata,
   output logic [3:0]                       gnt_idx,
   output logic                             err,
   output logic [15:0]                      svc_cnt
);
   logic [Data_Width-1:0] mem [2**Addr_Width];
   logic                  one_hot;
   logic                  multi;
   logic [3:0]            idx;
   logic [Addr_Width-1:0] a_sel;
   logic [Data_Width-1:0] d_sel;
   logic                  w_sel;

   assign one_hot = |gnt && ~|(gnt & (gnt - Req_Width'(1)));
   assign multi   = |gnt && !one_hot;

   // Slices are only meaningful when one_hot; multi-hot values are never used.
   always_comb begin
      idx   = '0;
      a_sel = '0;
      d_sel = '0;
      w_sel = 1'b0;
      for (int i = 0; i < Req_Width; i++)
         if (gnt[i]) begin
            idx   = 4'(i);
            a_sel = addr[i*Addr_Width +: Addr_Width];
            d_sel = wdata[i*Data_Width +: Data_Width];
            w_sel = we[i];
         end
   end

   always_ff @(posedge clk)
      if (one_hot && w_sel && !rst) mem[a_sel] <= d_sel;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ack     <= '0;
         ack_we  <= 1'b0;
         rdata   <= '0;
         gnt_idx <= '0;
         err     <= 1'b0;
         svc_cnt <= '0;
      end else begin
         ack    <= one_hot ? gnt : '0;
         ack_we <= one_hot && w_sel;
         if (one_hot) begin
            gnt_idx <= idx;
            if (!w_sel) rdata <= mem[a_sel];
            if (svc_cnt != 16'hFFFF) svc_cnt <= svc_cnt + 16'd1;
         end
         if (multi) err <= 1'b1;
      end
endmodule

// File: tb/tb_shared_mem_responder.sv
// tb_shared_mem_responder: directed vectors with hand-computed expectations.
module tb_shared_mem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  gnt = '0;
   logic [39:0] addr = '0;
   logic [79:0] wdata = '0;
   logic [9:0]  we = '0;
   logic [9:0]  ack;
   logic        ack_we;
   logic [7:0]  rdata;
   logic [3:0]  gnt_idx;
   logic        err;
   logic [15:0] svc_cnt;
   int          checks = 0;
   int          errors = 0;

   shared_mem_responder dut (
      .clk(clk), .rst(rst), .gnt(gnt), .addr(addr), .wdata(wdata), .we(we),
      .ack(ack), .ack_we(ack_we), .rdata(rdata), .gnt_idx(gnt_idx),
      .err(err), .svc_cnt(svc_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic w, input logic [3:0] a, input logic [7:0] d);
      gnt = '0;
      we = '0;
      gnt[i] = 1'b1;
      we[i] = w;
      addr[i*4 +: 4] = a;
      wdata[i*8 +: 8] = d;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ack"}, 32'(ack), 0);
      chk({tag, "_ack_we"}, 32'(ack_we), 0);
      chk({tag, "_rdata"}, 32'(rdata), 0);
      chk({tag, "_gnt_idx"}, 32'(gnt_idx), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_svc"}, 32'(svc_cnt), 0);
   endtask

   initial begin
      tick();
      tick();
      chk_zero("reset");
      rst = 1'b0;
      // write A5 to addr 3 via requester 2, read it back via requester 0
      put(2, 1'b1, 4'h3, 8'hA5);
      tick();
      chk("wr_ack", 32'(ack), 32'h004);
      chk("wr_ack_we", 32'(ack_we), 1);
      chk("wr_idx", 32'(gnt_idx), 2);
      put(0, 1'b0, 4'h3, 8'h00);
      tick();
      chk("rd_ack", 32'(ack), 32'h001);
      chk("rd_ack_we", 32'(ack_we), 0);
      chk("rd_data", 32'(rdata), 32'hA5);
      chk("rd_idx", 32'(gnt_idx), 0);
      chk("rd_svc", 32'(svc_cnt), 2);
      // sweep writes then reads
      for (int i = 0; i < 10; i++) begin
         put(i, 1'b1, 4'(i), 8'(i));
         tick();
         chk("sweep_wr_ack", 32'(ack), 32'(1 << i));
         chk("sweep_wr_rdata_hold", 32'(rdata), 32'hA5);
      end
      for (int i = 0; i < 10; i++) begin
         put(i, 1'b0, 4'(i), 8'h00);
         tick();
         chk("sweep_rd_ack", 32'(ack), 32'(1 << i));
         chk("sweep_rd_data", 32'(rdata), 32'(i));
         chk("sweep_rd_idx", 32'(gnt_idx), 32'(i));
      end
      chk("sweep_svc", 32'(svc_cnt), 22);
      // back-to-back write then read of the same address
      put(4, 1'b1, 4'h5, 8'h77);
      tick();
      put(7, 1'b0, 4'h5, 8'h00);
      tick();
      chk("b2b_data", 32'(rdata), 32'h77);
      chk("b2b_idx", 32'(gnt_idx), 7);
      // idle holds read data and index
      put(3, 1'b1, 4'h6, 8'h3C);
      tick();
      put(8, 1'b0, 4'h6, 8'h00);
      tick();
      chk("idle_pre_data", 32'(rdata), 32'h3C);
      gnt = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("idle_ack", 32'(ack), 0);
         chk("idle_data", 32'(rdata), 32'h3C);
         chk("idle_idx", 32'(gnt_idx), 8);
      end
      chk("idle_svc", 32'(svc_cnt), 26);
      // illegal multi-hot grant writes nothing and sets err
      gnt = 10'b0000001100;
      we = 10'b0000001100;
      addr[8 +: 4] = 4'h6;
      wdata[16 +: 8] = 8'hFF;
      addr[12 +: 4] = 4'h6;
      wdata[24 +: 8] = 8'hEE;
      tick();
      chk("ill_ack", 32'(ack), 0);
      chk("ill_err", 32'(err), 1);
      chk("ill_svc", 32'(svc_cnt), 26);
      chk("ill_idx", 32'(gnt_idx), 8);
      chk("ill_data", 32'(rdata), 32'h3C);
      put(1, 1'b0, 4'h6, 8'h00);
      tick();
      chk("ill_mem", 32'(rdata), 32'h3C);
      chk("ill_err_sticky", 32'(err), 1);
      chk("ill_svc_after", 32'(svc_cnt), 27);
      // async reset between edges while reads stream
      put(5, 1'b0, 4'h5, 8'h00);
      tick();
      chk("pre_rst_data", 32'(rdata), 32'h77);
      #3 rst = 1'b1;
      #1;
      chk_zero("async_rst");
      tick();
      rst = 1'b0;
      chk("rst_hold_ack", 32'(ack), 0);
      put(9, 1'b0, 4'h3, 8'h00);
      tick();
      chk("post_rst_ack", 32'(ack), 32'h200);
      chk("post_rst_data", 32'(rdata), 3);
      chk("post_rst_idx", 32'(gnt_idx), 9);
      chk("post_rst_svc", 32'(svc_cnt), 1);
      chk("post_rst_err", 32'(err), 0);
      // saturation of the service counter
      put(0, 1'b0, 4'h6, 8'h00);
      repeat (65533) tick();
      chk("sat_fffe", 32'(svc_cnt), 32'hFFFE);
      tick();
      chk("sat_ffff", 32'(svc_cnt), 32'hFFFF);
      repeat (5) tick();
      chk("sat_hold", 32'(svc_cnt), 32'hFFFF);
      chk("sat_ack", 32'(ack), 32'h001);
      chk("sat_data", 32'(rdata), 32'h3C);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/shared_mem_responder.md
SHARED_MEM_RESPONDER -- requirements
Module: shared_mem_responder

Interface
REQ-001 The block SHALL have parameter Req_Width, default 10, giving the number of requesters and the width of the one-hot grant vector.
REQ-002 The block SHALL have parameter Addr_Width, default 4, giving the word-address width; memory depth is 2**Addr_Width words.
REQ-003 The block SHALL have parameter Data_Width, default 8, giving the word width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 gnt  input  Req_Width  one-hot grant from the round-robin arbiter; all-zero means idle.
REQ-008 addr  input  Req_Width*Addr_Width  per-requester address; requester i occupies bits [i*Addr_Width +: Addr_Width].
REQ-009 wdata  input  Req_Width*Data_Width  per-requester write data; requester i occupies bits [i*Data_Width +: Data_Width].
REQ-010 we  input  Req_Width  per-requester write enable; 1 = write, 0 = read.
REQ-011 ack  output  Req_Width  registered one-hot completion strobe, one cycle wide.
REQ-012 ack_we  output  1  registered; 1 when the acknowledged access was a write.
REQ-013 rdata  output  Data_Width  registered read data.
REQ-014 gnt_idx  output  4  registered binary index of the last serviced requester.
REQ-015 err  output  1  sticky flag; set on an illegal, multi-hot gnt.
REQ-016 svc_cnt  output  16  saturating count of serviced accesses.

Function
REQ-017 Internal storage SHALL be 2**Addr_Width words of Data_Width bits; memory contents are not reset.
REQ-018 Sampling: at each rising edge the block SHALL decode gnt as idle (zero), legal (exactly one bit set) or illegal (two or more bits set).
REQ-019 Legal gnt with bit i set and we[i]=1: at that edge the block SHALL write wdata slice i to mem[addr slice i].
REQ-020 Legal gnt with bit i set and we[i]=0: at that edge the block SHALL load rdata with mem[addr slice i].
REQ-021 Latency: for a grant sampled at edge n, ack SHALL equal gnt, ack_we SHALL equal we[i], and gnt_idx SHALL equal i, all during cycle n+1; one access per cycle, no stall.
REQ-022 ack SHALL be all-zero in any cycle that follows an idle or illegal sample.
REQ-023 rdata SHALL hold its previous value after writes, idle and illegal samples.
REQ-024 gnt_idx SHALL hold its previous value after idle and illegal samples.
REQ-025 Back-to-back: a read at edge n+1 of an address written at edge n SHALL return the newly written data.
REQ-026 Illegal gnt: the block SHALL NOT access memory, SHALL NOT increment svc_cnt, and SHALL set err, which stays set until rst.
REQ-027 svc_cnt SHALL increment by 1 for each legal sample and saturate at 16'hFFFF without wrapping.
REQ-028 Reset mid-access: assertion of rst SHALL immediately clear all outputs; an access sampled at the same edge as rst deassertion SHALL be serviced normally.

Reset
REQ-029 While rst=1, outputs SHALL be: ack=0, ack_we=0, rdata=0, gnt_idx=0, err=0, svc_cnt=0.
REQ-030 Outputs SHALL change asynchronously on rst assertion, independent of clk.

Verification
REQ-031 Write then read: gnt=10'b0000000100, we[2]=1, addr2=4'h3, wdata2=8'hA5, then gnt=10'b0000000001, we[0]=0, addr0=4'h3 -> cycle 1: ack=10'b0000000100, ack_we=1; cycle 2: ack=10'b0000000001, rdata=8'hA5, gnt_idx=0.
REQ-032 Round-robin sweep: single grants to bits 0..9 in turn, each writing wdata=i to address i, then reading each back -> ack mirrors each grant one cycle later, rdata=i on each read, svc_cnt=20.
REQ-033 Illegal grant: gnt=10'b0000001100 -> next cycle ack=0, err=1, svc_cnt and memory unchanged; err stays 1 through subsequent legal traffic.
REQ-034 Idle: gnt=0 for 5 cycles after a read of 8'h3C -> ack=0, rdata stays 8'h3C, gnt_idx unchanged.
REQ-035 Saturation: force 65540 legal grants -> svc_cnt=16'hFFFF, no wrap.
REQ-036 Async reset: assert rst between clock edges during streaming grants -> all outputs 0 immediately; after deassertion, the first granted read returns the pre-reset memory contents.
